// File: rtl/proc_pkg.sv
// Shared definitions for the fetch unit and the processor: state encoding,
// opcode field position and the default special opcodes.
package proc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        ISSUE = 3'd3,
        WAIT  = 3'd4,
        HALT  = 3'd5
    } fetch_state_t;

    localparam int OP_HI = 15;
    localparam int OP_LO = 13;

    localparam logic [2:0] MVI_OP_DEF  = 3'b001;
    localparam logic [2:0] HALT_OP_DEF = 3'b111;

    function automatic logic [2:0] opcode_of(input logic [15:0] word);
        return word[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/pc_count.sv
// Program counter: wraps modulo 2^ADDR_W, advances only when inc is high.
module pc_count #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [ADDR_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: reads a synchronous program ROM, hands each word
// (plus an optional immediate) to the processor and waits for completion.
module instr_fetch
    import proc_pkg::*;
#(
    parameter int         ADDR_W  = 5,
    parameter logic [2:0] MVI_OP  = MVI_OP_DEF,
    parameter logic [2:0] HALT_OP = HALT_OP_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enable,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [15:0]       MemData,
    output logic [15:0]       DIN,
    output logic              Run,
    input  logic              Done,
    output logic [ADDR_W-1:0] PC,
    output logic              Halted
);

    fetch_state_t state;
    logic         load_halt;
    logic         issue_mvi;
    logic         pc_inc;

    assign load_halt = (opcode_of(MemData) == HALT_OP);
    assign issue_mvi = (opcode_of(DIN) == MVI_OP);

    // PC steps past the opcode word in LOAD and past the immediate in ISSUE.
    assign pc_inc = ((state == LOAD) && !load_halt) ||
                    ((state == ISSUE) && issue_mvi);

    pc_count #(.ADDR_W(ADDR_W)) u_pc (
        .clk   (Clock),
        .rst   (Reset),
        .inc   (pc_inc),
        .count (PC)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            DIN   <= 16'h0000;
        end else begin
            case (state)
                IDLE:  if (Enable) state <= FETCH;
                FETCH: state <= LOAD;
                LOAD: begin
                    if (load_halt) begin
                        state <= HALT;
                    end else begin
                        DIN   <= MemData;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // ROM already holds the word at PC+1 (addressed during LOAD).
                    if (issue_mvi) DIN <= MemData;
                    state <= WAIT;
                end
                WAIT:  if (Done) state <= Enable ? FETCH : IDLE;
                HALT:  state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    // Lookahead address in LOAD so the immediate word is ready during ISSUE.
    assign MemAddr = (state == LOAD) ? PC + ADDR_W'(1) : PC;
    assign Run     = (state == ISSUE);
    assign Halted  = (state == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: plain/immediate issue, halt, PC wrap,
// asynchronous reset and Enable/Done handling.
module tb_instr_fetch;

    localparam int ADDR_W = 5;

    logic              Clock;
    logic              Reset;
    logic              Enable;
    logic [ADDR_W-1:0] MemAddr;
    logic [15:0]       MemData;
    logic [15:0]       DIN;
    logic              Run;
    logic              Done;
    logic [ADDR_W-1:0] PC;
    logic              Halted;

    logic [15:0] rom [32];

    int checks = 0;
    int errors = 0;

    instr_fetch #(.ADDR_W(ADDR_W)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Enable  (Enable),
        .MemAddr (MemAddr),
        .MemData (MemData),
        .DIN     (DIN),
        .Run     (Run),
        .Done    (Done),
        .PC      (PC),
        .Halted  (Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Synchronous ROM: data for an address appears one cycle later.
    always @(posedge Clock) MemData <= rom[MemAddr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset  = 1'b1;
        Enable = 1'b0;
        Done   = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
        @(negedge Clock);
        @(negedge Clock);
    endtask

    task automatic start();
        Reset  = 1'b0;
        Enable = 1'b1;
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (Run !== 1'b1 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        check({tag, "_run_seen"}, Run, 1);
    endtask

    task automatic run_instr(input string tag);
        wait_run(tag);
        @(negedge Clock);
        Done = 1'b1;
        @(negedge Clock);
        Done = 1'b0;
    endtask

    initial begin
        int n;
        Reset   = 1'b1;
        Enable  = 1'b0;
        Done    = 1'b0;

        // Reset state and plain instruction issue.
        do_reset();
        check("rst_run", Run, 0);
        check("rst_din", DIN, 16'h0000);
        check("rst_pc", PC, 0);
        check("rst_addr", MemAddr, 0);
        check("rst_halted", Halted, 0);
        rom[0] = 16'h0240;
        rom[1] = 16'h4321;
        start();
        @(negedge Clock);
        check("a_fetch_run", Run, 0);
        check("a_fetch_addr", MemAddr, 0);
        @(negedge Clock);
        check("a_load_run", Run, 0);
        check("a_load_addr", MemAddr, 1);
        @(negedge Clock);
        check("a_issue_run", Run, 1);
        check("a_issue_din", DIN, 16'h0240);
        check("a_issue_pc", PC, 1);
        n = 0;
        repeat (3) begin
            @(negedge Clock);
            n += int'(Run);
        end
        check("a_wait_no_run", n, 0);
        check("a_wait_din", DIN, 16'h0240);
        Done = 1'b1;
        @(negedge Clock);
        Done = 1'b0;
        check("a_next_addr", MemAddr, 1);
        check("a_next_run", Run, 0);

        // Immediate-carrying instruction.
        do_reset();
        rom[0] = 16'h2000;
        rom[1] = 16'h00A5;
        start();
        repeat (3) @(negedge Clock);
        check("b_issue_run", Run, 1);
        check("b_issue_din", DIN, 16'h2000);
        @(negedge Clock);
        check("b_imm_din", DIN, 16'h00A5);
        check("b_imm_pc", PC, 2);
        check("b_imm_run", Run, 0);

        // Halt after two plain instructions.
        do_reset();
        rom[0] = 16'h0240;
        rom[1] = 16'h4100;
        rom[2] = 16'hE000;
        start();
        run_instr("c0");
        run_instr("c1");
        @(negedge Clock);
        @(negedge Clock);
        check("c_halted", Halted, 1);
        check("c_pc", PC, 2);
        check("c_addr", MemAddr, 2);
        check("c_din", DIN, 16'h4100);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            Done = (i % 2 == 0);
            @(negedge Clock);
            n += int'(Run);
        end
        Done = 1'b0;
        check("c_no_run", n, 0);
        check("c_still_halted", Halted, 1);
        check("c_pc_hold", PC, 2);

        // PC wrap across an immediate word.
        do_reset();
        rom[0] = 16'h1234;
        for (int i = 1; i < 31; i++) rom[i] = 16'h0400 + 16'(i);
        rom[31] = 16'h2000;
        start();
        for (int i = 0; i < 31; i++) run_instr("d_step");
        check("d_pc31", PC, 31);
        wait_run("d_mvi");
        check("d_mvi_din", DIN, 16'h2000);
        check("d_mvi_pc", PC, 0);
        @(negedge Clock);
        check("d_imm_din", DIN, 16'h1234);
        check("d_imm_pc", PC, 1);

        // Asynchronous reset during ISSUE and during WAIT.
        do_reset();
        rom[0] = 16'h0240;
        start();
        wait_run("e0");
        Reset = 1'b1;
        #1;
        check("e_issue_rst_run", Run, 0);
        check("e_issue_rst_pc", PC, 0);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        check("e_relaunch_early", Run, 0);
        @(negedge Clock);
        check("e_relaunch_run", Run, 1);
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        check("e_wait_rst_run", Run, 0);
        check("e_wait_rst_din", DIN, 16'h0000);
        check("e_wait_rst_pc", PC, 0);
        check("e_wait_rst_addr", MemAddr, 0);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("e_again_c1", Run, 0);
        @(negedge Clock);
        check("e_again_c2", Run, 0);
        @(negedge Clock);
        check("e_again_run", Run, 1);
        check("e_again_din", DIN, 16'h0240);
        check("e_again_pc", PC, 1);

        // Done ignored during ISSUE; Enable low at WAIT exit returns to IDLE.
        do_reset();
        rom[0] = 16'h0240;
        rom[1] = 16'h4100;
        start();
        wait_run("f0");
        Done   = 1'b1;
        Enable = 1'b0;
        @(negedge Clock);
        Done = 1'b0;
        check("f_wait_addr", MemAddr, 1);
        Enable = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge Clock);
            n += int'(Run);
        end
        check("f_wait_hold", n, 0);
        Enable = 1'b0;
        Done   = 1'b1;
        @(negedge Clock);
        Done = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge Clock);
            n += int'(Run);
        end
        check("f_idle_no_run", n, 0);
        check("f_idle_addr", MemAddr, 1);
        Enable = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        check("f_resume_early", Run, 0);
        @(negedge Clock);
        check("f_resume_run", Run, 1);
        check("f_resume_din", DIN, 16'h4100);
        check("f_resume_pc", PC, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
